axis_diag_serializer: RTL and testbench

Parametrised AXI-Stream master that buffers the diagonal result vectors produced by the systolic matrix-multiply core (`o_c_diag_to_buffer`, SIZE×O_BITS bits) and streams them out as multi-lane beats on the M00_AXIS port. It replaces the fixed single-size output path: the active matrix size is selectable at run time through `rf_matrix_size`, lanes per beat and buffer depth are parameters, and end-of-matrix framing is carried on `tlast`. It sits between the `top_AXI_Interface` compute array and the DMA/interconnect.

---
 rtl/axis_diag_serializer_if.sv | 14 +
 rtl/axis_diag_serializer.sv | 136 +++++++++++++
 tb/tb_axis_diag_serializer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_diag_serializer_if.sv
// AXI-Stream channel carrying the serialized diagonal beats (M00_AXIS).
// master drives payload and tvalid, slave drives tready.
interface axis_diag_serializer_if #(
   parameter int TDATA_W = 32
) ();
   logic                   tvalid;
   logic [TDATA_W-1:0]     tdata;
   logic [TDATA_W/8-1:0]   tstrb;
   logic                   tlast;
   logic                   tready;

   modport master (output tvalid, output tdata, output tstrb, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tstrb, input tlast, output tready);
endinterface

// File: rtl/axis_diag_serializer.sv
// Buffers diagonal result vectors from the systolic core in a small FIFO and
// streams each one out as ceil(N/LANES) multi-lane AXIS beats, tlast on matrix end.
module axis_diag_serializer #(
   parameter int SIZE   = 32,
   parameter int O_BITS = 16,
   parameter int LANES  = 2,
   parameter int DEPTH  = 4
) (
   input  logic                        i_clock,
   input  logic                        i_reset,
   input  logic                        i_valid,
   input  logic                        i_last,
   input  logic [SIZE*O_BITS-1:0]      i_diag,
   input  logic [2:0]                  rf_matrix_size,
   output logic                        o_ready,
   output logic [$clog2(DEPTH+1)-1:0]  o_level,
   output logic                        o_overflow,
   output logic [0:0]                  o_state,
   axis_diag_serializer_if.master      m00_axis
);

   localparam int C_M00_AXIS_TDATA_WIDTH = LANES * O_BITS;
   localparam int LANE_BYTES = O_BITS / 8;
   localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW         = $clog2(DEPTH + 1);
   localparam int NW         = $clog2(SIZE + 1);
   localparam int LOG_SIZE   = $clog2(SIZE);
   localparam int BEATS_MAX  = SIZE / LANES;
   localparam int BW         = (BEATS_MAX > 1) ? $clog2(BEATS_MAX) : 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   logic [SIZE*O_BITS-1:0] mem_diag [DEPTH];
   logic                   mem_last [DEPTH];
   logic [NW-1:0]          mem_n    [DEPTH];

   logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]  level_q, level_next;
   logic [0:0]     state_q;
   logic [BW-1:0]  beat_q;
   logic           overflow_q;

   logic [NW-1:0]          n_push;
   logic [SIZE*O_BITS-1:0] head_diag;
   logic                   head_last;
   logic [NW-1:0]          head_n, head_beats;
   logic                   push, hs, last_beat, pop;
   logic [31:0]            lane_idx;

   // Handshake: a beat transfers on any edge where tvalid && tready; tvalid only
   // falls after the final beat's transfer, and payload is a pure function of
   // head slot and beat counter, so it cannot move while stalled.
   assign m00_axis.tvalid = (state_q == ST_SEND);
   assign hs              = m00_axis.tvalid && m00_axis.tready;

   assign o_ready    = (level_q != LW'(DEPTH));
   assign o_level    = level_q;
   assign o_overflow = overflow_q;
   assign o_state    = state_q;
   assign push       = i_valid && o_ready;

   always_comb begin
      n_push = NW'(SIZE);
      if (int'(rf_matrix_size) < LOG_SIZE)
         n_push = NW'(1) << rf_matrix_size;
   end

   assign head_diag  = mem_diag[rd_ptr_q];
   assign head_last  = mem_last[rd_ptr_q];
   assign head_n     = mem_n[rd_ptr_q];
   assign head_beats = (head_n + NW'(LANES - 1)) / NW'(LANES);
   assign last_beat  = (NW'(beat_q) == head_beats - NW'(1));
   assign pop        = hs && last_beat;
   assign level_next = level_q + LW'(push) - LW'(pop);

   assign m00_axis.tlast = (state_q == ST_SEND) && last_beat && head_last;

   // Lanes past the active dimension N carry zero data and zero strobes.
   always_comb begin
      m00_axis.tdata = '0;
      m00_axis.tstrb = '0;
      lane_idx       = '0;
      for (int l = 0; l < LANES; l++) begin
         lane_idx = 32'(beat_q) * 32'(LANES) + 32'(l);
         if (state_q == ST_SEND && lane_idx < 32'(head_n)) begin
            m00_axis.tdata[l*O_BITS +: O_BITS]         = head_diag[lane_idx*O_BITS +: O_BITS];
            m00_axis.tstrb[l*LANE_BYTES +: LANE_BYTES] = '1;
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (push) begin
         mem_diag[wr_ptr_q] <= i_diag;
         mem_last[wr_ptr_q] <= i_last;
         mem_n[wr_ptr_q]    <= n_push;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         state_q    <= ST_IDLE;
         beat_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         level_q <= level_next;
         if (i_valid && !o_ready)
            overflow_q <= 1'b1;
         if (push)
            wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)
            rd_ptr_q <= rd_ptr_q + AW'(1);

         if (pop)
            beat_q <= '0;
         else if (hs)
            beat_q <= beat_q + BW'(1);

         // A newly stored head may start the cycle after the old one's final beat.
         case (state_q)
            ST_IDLE: if (level_q != '0) state_q <= ST_SEND;
            ST_SEND: if (pop && level_next == '0) state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   if (C_M00_AXIS_TDATA_WIDTH % 8 != 0) begin : g_bad_width
      $error("tdata width must be a whole number of bytes");
   end

endmodule

// File: tb/tb_axis_diag_serializer.sv
// Randomized bench for axis_diag_serializer: a vector-level model expands each
// accepted push into its expected beats and tracks FIFO occupancy per cycle.
module tb_axis_diag_serializer;

   localparam int SIZE   = 32;
   localparam int O_BITS = 16;
   localparam int LANES  = 2;
   localparam int DEPTH  = 4;
   localparam int TW     = LANES * O_BITS;
   localparam int SW     = TW / 8;
   localparam int LW     = $clog2(DEPTH + 1);
   localparam int EW     = TW + SW + 2;

   logic                    i_clock = 1'b0;
   logic                    i_reset;
   logic                    i_valid;
   logic                    i_last;
   logic [SIZE*O_BITS-1:0]  i_diag;
   logic [2:0]              rf_matrix_size;
   logic                    o_ready;
   logic [LW-1:0]           o_level;
   logic                    o_overflow;
   logic [0:0]              o_state;

   axis_diag_serializer_if #(.TDATA_W(TW)) m00_axis ();

   axis_diag_serializer #(
      .SIZE(SIZE), .O_BITS(O_BITS), .LANES(LANES), .DEPTH(DEPTH)
   ) dut (
      .i_clock(i_clock),
      .i_reset(i_reset),
      .i_valid(i_valid),
      .i_last(i_last),
      .i_diag(i_diag),
      .rf_matrix_size(rf_matrix_size),
      .o_ready(o_ready),
      .o_level(o_level),
      .o_overflow(o_overflow),
      .o_state(o_state),
      .m00_axis(m00_axis)
   );

   // clock / reset
   always #5 i_clock = ~i_clock;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // scoreboard: each entry is {end_of_vector, tlast, tstrb, tdata}
   logic [EW-1:0] exp_q[$];
   int            lvl      = 0;
   int            lvl_prev = 0;
   logic          ovf      = 1'b0;
   logic          exp_tv;
   logic          pushed;
   logic          popped_eov;
   logic [EW-1:0] cur;
   bit            mon_en   = 1'b0;

   function automatic void model_push(input logic [SIZE*O_BITS-1:0] d, input logic lst,
                                      input logic [2:0] rf);
      int n;
      int nb;
      logic [TW-1:0] data;
      logic [SW-1:0] strb;
      n = 1 << rf;
      if (n > SIZE) n = SIZE;
      nb = (n + LANES - 1) / LANES;
      for (int b = 0; b < nb; b++) begin
         data = '0;
         strb = '0;
         for (int l = 0; l < LANES; l++) begin
            if (b * LANES + l < n) begin
               data[l*O_BITS +: O_BITS]       = d[(b*LANES+l)*O_BITS +: O_BITS];
               strb[l*(O_BITS/8) +: O_BITS/8] = '1;
            end
         end
         exp_q.push_back({(b == nb - 1), lst && (b == nb - 1), strb, data});
      end
   endfunction

   // Checks the state reached at the last edge, then predicts the next edge.
   // A stream is visible once a vector has been stored across a whole cycle.
   always @(negedge i_clock) begin
      if (mon_en) begin
         exp_tv = (lvl_prev != 0) && (lvl != 0);
         check("level", 64'(o_level), 64'(lvl));
         check("ready", 64'(o_ready), 64'(lvl < DEPTH));
         check("overflow", 64'(o_overflow), 64'(ovf));
         check("state", 64'(o_state), 64'(exp_tv));
         check("tvalid", 64'(m00_axis.tvalid), 64'(exp_tv));
         if (exp_tv) begin
            check("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
               cur = exp_q[0];
               check("tdata", 64'(m00_axis.tdata), 64'(cur[TW-1:0]));
               check("tstrb", 64'(m00_axis.tstrb), 64'(cur[TW+SW-1:TW]));
               check("tlast", 64'(m00_axis.tlast), 64'(cur[TW+SW]));
            end
         end
         if (i_reset) begin
            exp_q.delete();
            lvl      = 0;
            lvl_prev = 0;
            ovf      = 1'b0;
         end else begin
            popped_eov = 1'b0;
            if (exp_tv && m00_axis.tready && exp_q.size() != 0) begin
               cur        = exp_q.pop_front();
               popped_eov = cur[TW+SW+1];
            end
            pushed = i_valid && (lvl < DEPTH);
            if (i_valid && !pushed) ovf = 1'b1;
            if (pushed) model_push(i_diag, i_last, rf_matrix_size);
            lvl_prev = lvl;
            lvl      = lvl + int'(pushed) - int'(popped_eov);
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge i_clock);
      #1;
   endtask

   function automatic logic [SIZE*O_BITS-1:0] rand_diag();
      logic [SIZE*O_BITS-1:0] d;
      for (int i = 0; i < SIZE * O_BITS / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic push_vec(input logic [2:0] rf, input logic lst, input logic [SIZE*O_BITS-1:0] d);
      i_valid        = 1'b1;
      i_last         = lst;
      rf_matrix_size = rf;
      i_diag         = d;
      tick();
      i_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 300 && (o_level != '0 || m00_axis.tvalid); i++) tick();
      check(tag, 64'(o_level == '0 && !m00_axis.tvalid), 64'(1));
   endtask

   logic [SIZE*O_BITS-1:0] d;
   logic [O_BITS-1:0]      e0;
   logic                   pat [4];

   initial begin
      i_reset = 1'b1;
      i_valid = 1'b1;
      i_last  = 1'b0;
      i_diag  = rand_diag();
      rf_matrix_size   = 3'd0;
      m00_axis.tready  = 1'b1;
      tick();
      mon_en = 1'b1;
      tick();
      i_reset = 1'b0;
      i_valid = 1'b0;

      // reset values, valid-during-reset ignored
      @(negedge i_clock);
      check("rst_ready", 64'(o_ready), 64'(1));
      check("rst_level", 64'(o_level), 64'(0));
      check("rst_ovf", 64'(o_overflow), 64'(0));
      check("rst_tvalid", 64'(m00_axis.tvalid), 64'(0));
      check("rst_tdata", 64'(m00_axis.tdata), 64'(0));
      check("rst_tstrb", 64'(m00_axis.tstrb), 64'(0));
      check("rst_tlast", 64'(m00_axis.tlast), 64'(0));
      tick();

      // single N=4 vector: beats {2,1} then {4,3}
      d = rand_diag();
      d[0*O_BITS +: O_BITS] = 16'd1;
      d[1*O_BITS +: O_BITS] = 16'd2;
      d[2*O_BITS +: O_BITS] = 16'd3;
      d[3*O_BITS +: O_BITS] = 16'd4;
      push_vec(3'd2, 1'b1, d);
      @(negedge i_clock);
      check("lat_tvalid0", 64'(m00_axis.tvalid), 64'(0));
      @(negedge i_clock);
      check("b0_tvalid", 64'(m00_axis.tvalid), 64'(1));
      check("b0_tdata", 64'(m00_axis.tdata), 64'h0002_0001);
      check("b0_tstrb", 64'(m00_axis.tstrb), 64'hF);
      check("b0_tlast", 64'(m00_axis.tlast), 64'(0));
      @(negedge i_clock);
      check("b1_tdata", 64'(m00_axis.tdata), 64'h0004_0003);
      check("b1_tlast", 64'(m00_axis.tlast), 64'(1));
      @(negedge i_clock);
      check("b2_tvalid", 64'(m00_axis.tvalid), 64'(0));
      tick();

      // partial lane fill: N=1 leaves lane 1 empty
      d  = rand_diag();
      e0 = d[O_BITS-1:0];
      push_vec(3'd0, 1'b0, d);
      @(negedge i_clock);
      @(negedge i_clock);
      check("odd_tdata", 64'(m00_axis.tdata), 64'({16'h0, e0}));
      check("odd_tstrb", 64'(m00_axis.tstrb), 64'h3);
      check("odd_tlast", 64'(m00_axis.tlast), 64'(0));
      tick();
      wait_idle("odd_idle");

      // back-pressure over a 16-beat vector
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      push_vec(3'd5, 1'b1, rand_diag());
      for (int i = 0; i < 64; i++) begin
         m00_axis.tready = pat[i % 4];
         tick();
      end
      m00_axis.tready = 1'b1;
      wait_idle("bp_idle");

      // fill to DEPTH, overflow on the fifth push
      m00_axis.tready = 1'b0;
      for (int k = 0; k < 4; k++) push_vec(3'd2, k == 3, rand_diag());
      @(negedge i_clock);
      check("full_ready", 64'(o_ready), 64'(0));
      check("full_level", 64'(o_level), 64'(DEPTH));
      tick();
      push_vec(3'd2, 1'b1, rand_diag());
      @(negedge i_clock);
      check("ovf_set", 64'(o_overflow), 64'(1));
      check("ovf_level", 64'(o_level), 64'(DEPTH));
      tick();
      m00_axis.tready = 1'b1;
      wait_idle("ovf_drain");
      check("ovf_sticky", 64'(o_overflow), 64'(1));

      // reset at beat 3 of a 16-beat vector with two more queued
      m00_axis.tready = 1'b0;
      for (int k = 0; k < 3; k++) push_vec(3'd5, 1'b0, rand_diag());
      tick();
      m00_axis.tready = 1'b1;
      repeat (3) tick();
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      @(negedge i_clock);
      check("mid_rst_tvalid", 64'(m00_axis.tvalid), 64'(0));
      check("mid_rst_level", 64'(o_level), 64'(0));
      tick();
      push_vec(3'd5, 1'b1, rand_diag());
      wait_idle("post_rst_idle");

      // randomized traffic
      for (int i = 0; i < 700; i++) begin
         i_valid         = ($urandom_range(0, 2) != 0);
         i_last          = $urandom_range(0, 1) != 0;
         rf_matrix_size  = 3'($urandom_range(0, 7));
         i_diag          = rand_diag();
         m00_axis.tready = ($urandom_range(0, 3) != 0);
         tick();
      end
      i_valid         = 1'b0;
      m00_axis.tready = 1'b1;
      wait_idle("rand_drain");
      @(negedge i_clock);
      check("sb_empty", 64'(exp_q.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
